// File: rtl/serial_mult_io_p.sv
// Word-serial operand loader feeding a shift-add multiplier with a busy/done handshake.
// Optional two's-complement mode is enabled by defining SERIAL_MULT_SIGNED_EN.
module serial_mult_io_p #(
  parameter int IN_W = 8,
  parameter int OP_W = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IN_W-1:0]                   data_in,
  input  logic                              ctrl,
  output logic [2*OP_W-1:0]                 product,
  output logic                              done,
  output logic                              busy,
  output logic [$clog2(2*OP_W/IN_W):0]      load_cnt
);

  localparam int N     = OP_W / IN_W;
  localparam int WORDS = 2 * N;
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam int BIT_W = $clog2(OP_W) + 1;

  generate
    if (((OP_W % IN_W) != 0) || (OP_W < IN_W)) begin : g_bad_widths
      $error("serial_mult_io_p: OP_W must be a multiple of IN_W and >= IN_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic                 ctrl_d_r;
  logic [2*OP_W-1:0]    ops_r;
  logic [OP_W-1:0]      mcand_r;
  logic [OP_W-1:0]      mplr_r;
  logic [2*OP_W-1:0]    acc_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [2*OP_W-1:0]    product_r;
  logic                 done_r;
  logic                 busy_r;
  logic [CNT_W-1:0]     load_cnt_r;

  logic                 stb_s;
  logic                 last_word_s;
  logic                 mul_last_s;
  logic [2*OP_W-1:0]    ops_next_s;
  logic [OP_W-1:0]      op_a_s;
  logic [OP_W-1:0]      op_b_s;
  logic [OP_W-1:0]      mag_a_s;
  logic [OP_W-1:0]      mag_b_s;
  logic [OP_W:0]        sum_s;
  logic [2*OP_W-1:0]    acc_next_s;
  logic [2*OP_W-1:0]    result_s;

  assign stb_s       = ctrl & ~ctrl_d_r;
  assign last_word_s = (load_cnt_r == CNT_W'(WORDS - 1));
  assign mul_last_s  = (bit_cnt_r == BIT_W'(OP_W - 1));
  assign op_a_s      = ops_next_s[OP_W-1:0];
  assign op_b_s      = ops_next_s[2*OP_W-1:OP_W];

  // Operand image with the incoming word dropped into the slot chosen by load_cnt
  always_comb begin
    ops_next_s = ops_r;
    for (int i = 0; i < WORDS; i++) begin
      if (load_cnt_r == CNT_W'(i)) begin
        ops_next_s[i*IN_W +: IN_W] = data_in;
      end else begin
        ops_next_s[i*IN_W +: IN_W] = ops_r[i*IN_W +: IN_W];
      end
    end
  end

  // One shift-add step: conditional add into the upper half (carry kept), then shift right
  always_comb begin
    if (mplr_r[0]) begin
      sum_s = {1'b0, acc_r[2*OP_W-1:OP_W]} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r[2*OP_W-1:OP_W]};
    end
    acc_next_s = {sum_s, acc_r[OP_W-1:1]};
  end

`ifdef SERIAL_MULT_SIGNED_EN
  logic neg_r;

  function automatic logic [OP_W-1:0] neg_op(input logic [OP_W-1:0] x);
    return ~x + {{(OP_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*OP_W-1:0] neg_prod(input logic [2*OP_W-1:0] x);
    return ~x + {{(2*OP_W-1){1'b0}}, 1'b1};
  endfunction

  // -2^(OP_W-1) negates to itself, which is the correct unsigned magnitude
  assign mag_a_s  = op_a_s[OP_W-1] ? neg_op(op_a_s) : op_a_s;
  assign mag_b_s  = op_b_s[OP_W-1] ? neg_op(op_b_s) : op_b_s;
  assign result_s = neg_r ? neg_prod(acc_next_s) : acc_next_s;

  // Result sign captured alongside the magnitudes on the load-complete edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_r <= 1'b0;
    end else if ((state_r == ST_LOAD) && stb_s && last_word_s) begin
      neg_r <= op_a_s[OP_W-1] ^ op_b_s[OP_W-1];
    end else begin
      neg_r <= neg_r;
    end
  end
`else
  assign mag_a_s  = op_a_s;
  assign mag_b_s  = op_b_s;
  assign result_s = acc_next_s;
`endif

  // Main controller: strobe edge detect, word loading, multiply sequencing and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_LOAD;
      ctrl_d_r   <= 1'b0;
      ops_r      <= '0;
      mcand_r    <= '0;
      mplr_r     <= '0;
      acc_r      <= '0;
      bit_cnt_r  <= '0;
      product_r  <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      load_cnt_r <= '0;
    end else begin
      ctrl_d_r <= ctrl;
      case (state_r)
        ST_LOAD: begin
          if (stb_s) begin
            ops_r <= ops_next_s;
            if (last_word_s) begin
              load_cnt_r <= '0;
              acc_r      <= '0;
              bit_cnt_r  <= '0;
              mcand_r    <= mag_a_s;
              mplr_r     <= mag_b_s;
              busy_r     <= 1'b1;
              state_r    <= ST_MUL;
            end else begin
              load_cnt_r <= load_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_MUL: begin
          // Strobes are deliberately ignored here; the edge detector still tracks ctrl
          acc_r     <= acc_next_s;
          mplr_r    <= mplr_r >> 1;
          bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          if (mul_last_s) begin
            product_r <= result_s;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (stb_s) begin
            ops_r      <= ops_next_s;
            done_r     <= 1'b0;
            load_cnt_r <= CNT_W'(1);
            state_r    <= ST_LOAD;
          end
        end
        default: begin
          state_r    <= ST_LOAD;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          load_cnt_r <= '0;
        end
      endcase
    end
  end

  assign product  = product_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign load_cnt = load_cnt_r;

endmodule

// File: tb/tb_serial_mult_io_p.sv
// Directed bench for serial_mult_io_p (IN_W=8, OP_W=16); expectations follow SERIAL_MULT_SIGNED_EN.
module tb_serial_mult_io_p;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        ctrl;
  logic [31:0] product;
  logic        done;
  logic        busy;
  logic [2:0]  load_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SERIAL_MULT_SIGNED_EN
  localparam logic [31:0] EXP_FFFF_FFFF = 32'h00000001;
  localparam logic [31:0] EXP_FFFF_0002 = 32'hFFFFFFFE;
  localparam logic [31:0] EXP_FFFE_0003 = 32'hFFFFFFFA;
`else
  localparam logic [31:0] EXP_FFFF_FFFF = 32'hFFFE0001;
  localparam logic [31:0] EXP_FFFF_0002 = 32'h0001FFFE;
  localparam logic [31:0] EXP_FFFE_0003 = 32'h0002FFFA;
`endif

  serial_mult_io_p #(.IN_W(8), .OP_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .ctrl     (ctrl),
    .product  (product),
    .done     (done),
    .busy     (busy),
    .load_cnt (load_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one word: ctrl high for two clocks, then low for one
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    ctrl    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ctrl = 1'b0;
  endtask

  task automatic load_head(input logic [15:0] a, input logic [15:0] b);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
  endtask

  // final word; returns the number of rising edges from its capture until done is seen
  task automatic load_tail(input logic [7:0] w, input bit mid_stb, output int edges);
    @(negedge clk);
    data_in = w;
    ctrl    = 1'b1;
    @(posedge clk);
    edges = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) ctrl = 1'b0;
      if (mid_stb && edges == 5) begin
        data_in = 8'hEE;
        ctrl    = 1'b1;
      end
      if (edges == 7) ctrl = 1'b0;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({product, done, busy, load_cnt} !== {32'h0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_state: product=%h done=%b busy=%b load_cnt=%0d, want 0/0/0/0",
               product, done, busy, load_cnt);
    end
  endtask

  task automatic test_basic();
    int edges;
    load_head(16'h1234, 16'h5678);
    n_tests++;
    if (load_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL basic_cnt: load_cnt=%0d want 3", load_cnt);
    end
    load_tail(8'h56, 1'b0, edges);
    n_tests++;
    if (edges !== 16) begin
      n_fail++;
      $display("FAIL basic_latency: edges=%0d want 16", edges);
    end
    n_tests++;
    if (product !== 32'h06260060) begin
      n_fail++;
      $display("FAIL basic_product: got %h want 06260060", product);
    end
    n_tests++;
    if ({done, busy, load_cnt} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL basic_flags: done=%b busy=%b load_cnt=%0d want 1/0/0", done, busy, load_cnt);
    end
  endtask

  task automatic test_operands();
    int edges;
    logic [15:0] va [5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h8000, 16'hFFFE};
    logic [15:0] vb [5] = '{16'hFFFF, 16'h1234, 16'h0002, 16'h8000, 16'h0003};
    logic [31:0] ve [5] = '{EXP_FFFF_FFFF, 32'h0, EXP_FFFF_0002, 32'h40000000, EXP_FFFE_0003};
    for (int i = 0; i < 5; i++) begin
      load_head(va[i], vb[i]);
      load_tail(vb[i][15:8], 1'b0, edges);
      n_tests++;
      if (edges !== 16) begin
        n_fail++;
        $display("FAIL op%0d_latency: edges=%0d want 16", i, edges);
      end
      n_tests++;
      if (product !== ve[i]) begin
        n_fail++;
        $display("FAIL op%0d_product: A=%h B=%h got %h want %h", i, va[i], vb[i], product, ve[i]);
      end
    end
  endtask

  task automatic test_strobe_rules();
    int edges;
    @(negedge clk);
    data_in = 8'hAA;
    ctrl    = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (load_cnt !== 3'd1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL held_ctrl: load_cnt=%0d done=%b want 1/0", load_cnt, done);
    end
    ctrl = 1'b0;
    send_byte(8'h00);
    send_byte(8'h03);
    load_tail(8'h00, 1'b1, edges);
    n_tests++;
    if (edges !== 16) begin
      n_fail++;
      $display("FAIL mul_stb_latency: edges=%0d want 16", edges);
    end
    n_tests++;
    if (product !== 32'h000001FE || load_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL mul_stb_ignored: product=%h load_cnt=%0d want 000001fe/0", product, load_cnt);
    end
  endtask

  task automatic test_reset_mid_mul();
    int edges;
    load_head(16'h1111, 16'h2222);
    @(negedge clk);
    data_in = 8'h22;
    ctrl    = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mul_busy: busy=%b want 1", busy);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({product, done, busy, load_cnt} !== {32'h0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset: product=%h done=%b busy=%b load_cnt=%0d want 0/0/0/0",
               product, done, busy, load_cnt);
    end
    ctrl = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    load_head(16'h0003, 16'h0005);
    load_tail(8'h00, 1'b0, edges);
    n_tests++;
    if (edges !== 16 || product !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL after_reset: edges=%0d product=%h want 16/0000000f", edges, product);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    send_byte(8'h02);
    n_tests++;
    if ({done, load_cnt, product} !== {1'b0, 3'd1, 32'h0000000F}) begin
      n_fail++;
      $display("FAIL b2b_first_word: done=%b load_cnt=%0d product=%h want 0/1/0000000f",
               done, load_cnt, product);
    end
    send_byte(8'h01);
    send_byte(8'h04);
    n_tests++;
    if (product !== 32'h0000000F || load_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL b2b_hold: product=%h load_cnt=%0d want 0000000f/3", product, load_cnt);
    end
    load_tail(8'h03, 1'b0, edges);
    n_tests++;
    if (edges !== 16 || product !== 32'h00030A08 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: edges=%0d product=%h done=%b want 16/00030a08/1",
               edges, product, done);
    end
  endtask

  initial begin
    rst     = 1'b0;
    ctrl    = 1'b0;
    data_in = 8'h00;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_basic();
    test_operands();
    test_reset_mid_mul();
    test_back_to_back();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (20) @(negedge clk);
    test_strobe_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
